// File: rtl/train_top.sv
// train_top: AXI-Lite controlled batch engine. Characters arrive on S_AXIS,
// are biased one per cycle in RUN, and are streamed back out on M_AXIS.
// TRAIN mode bumps the bias after each batch; FORWARD returns sample 0 only.
// Optional feature: define LED_STATUS_EN to drive led_out with core status,
// otherwise led_out is tied to zero.
module train_top #(
  parameter int unsigned CHAR_LEN           = 8,
  parameter int unsigned N                  = 4,
  parameter int unsigned BATCH_SIZE         = 2,
  parameter int unsigned MODE_LEN           = 2,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  output logic [3:0]                        led_out,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [CHAR_LEN-1:0]               S_AXIS_TDATA,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic [CHAR_LEN-1:0]               M_AXIS_TDATA,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY
);

  localparam int unsigned BN     = BATCH_SIZE * N;
  localparam int unsigned IDX_W  = (BN > 1) ? $clog2(BN) : 1;
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [MODE_LEN-1:0] MODE_TRAIN = MODE_LEN'(1);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(BN - 1);
  localparam logic [IDX_W-1:0]    LAST_FWD   = IDX_W'(N - 1);
  localparam logic [IDX_W:0]      WIDX_END   = (IDX_W + 1)'(BN);

  typedef enum logic [1:0] {ST_RECV, ST_WAIT, ST_RUN, ST_OUT} state_e;

  // AXI-Lite register file and handshake state
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_ctrl, reg_mode, rdata_q, rd_mux_c;
  logic                          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic                          wr_accept_c, rd_accept_c;
  logic [3:1]                    ctrl_prev_q;
  logic                          core_en_c, run_edge_c, set_edge_c, next_edge_c;

  // Core state
  state_e                        state_q, state_d;
  logic                          finish_q, train_q, busy_c;
  logic [CHAR_LEN-1:0]           bias_q;
  logic [IDX_W:0]                widx_q;
  logic [IDX_W-1:0]              ridx_q, oidx_q, oidx_n_c, out_last_c;
  logic                          s_tready_q, m_tvalid_q, m_tlast_q;
  logic [CHAR_LEN-1:0]           m_tdata_q, run_char_c;
  logic                          s_hs_c, wr_store_c, m_hs_c, run_done_c, out_done_c, next_last_c;

  logic [CHAR_LEN-1:0]           in_buf  [BN];
  logic [CHAR_LEN-1:0]           out_buf [BN];

  logic                          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXIS_TREADY = s_tready_q;
  assign M_AXIS_TDATA  = m_tdata_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TVALID = m_tvalid_q;

  assign wr_accept_c = !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_accept_c = !arready_q && S_AXI_ARVALID && !rvalid_q;

  assign core_en_c   = reg_ctrl[0];
  assign run_edge_c  = reg_ctrl[1] & ~ctrl_prev_q[1];
  assign set_edge_c  = reg_ctrl[2] & ~ctrl_prev_q[2];
  assign next_edge_c = reg_ctrl[3] & ~ctrl_prev_q[3];

  assign busy_c      = (state_q == ST_RUN) || (state_q == ST_OUT);
  assign s_hs_c      = core_en_c && (state_q == ST_RECV) && s_tready_q && S_AXIS_TVALID;
  assign wr_store_c  = s_hs_c && (widx_q < WIDX_END);
  assign m_hs_c      = m_tvalid_q && M_AXIS_TREADY;
  assign out_last_c  = train_q ? LAST_IDX : LAST_FWD;
  assign run_done_c  = (ridx_q == LAST_IDX);
  assign out_done_c  = m_hs_c && (oidx_q == out_last_c);
  assign oidx_n_c    = oidx_q + IDX_W'(1);
  assign next_last_c = ((32'(oidx_n_c) % N) == (N - 1));
  assign run_char_c  = in_buf[ridx_q] + bias_q;

  // Register writes and write-channel handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      reg_ctrl  <= C_S_AXI_DATA_WIDTH'(1);
      reg_mode  <= '0;
    end else begin
      awready_q <= wr_accept_c;
      wready_q  <= wr_accept_c;
      if (wr_accept_c) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (wr_accept_c) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (S_AXI_WSTRB[b]) begin
            case (S_AXI_AWADDR[3:2])
              2'd0:    reg_ctrl[b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
              2'd1:    reg_mode[b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Read data selection
  always_comb begin
    rd_mux_c = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux_c = reg_ctrl;
      2'd1:    rd_mux_c = reg_mode;
      2'd2:    rd_mux_c = C_S_AXI_DATA_WIDTH'({busy_c, finish_q});
      default: rd_mux_c = '0;
    endcase
  end

  // Read-channel handshake; a read is taken whenever no response is pending
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= rd_accept_c;
      if (rd_accept_c) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux_c;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Previous control bits for rising-edge detection
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_prev_q <= '0;
    end else begin
      ctrl_prev_q <= reg_ctrl[3:1];
    end
  end

  // Core state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_RECV;
    end else begin
      state_q <= state_d;
    end
  end

  // Core next-state logic; ctrl.rst_n low forces RECV
  always_comb begin
    state_d = state_q;
    if (!core_en_c) begin
      state_d = ST_RECV;
    end else begin
      case (state_q)
        ST_RECV: if (s_hs_c && S_AXIS_TLAST) state_d = ST_WAIT;
        ST_WAIT: if (run_edge_c)             state_d = ST_RUN;
        ST_RUN:  if (run_done_c)             state_d = ST_OUT;
        ST_OUT:  if (out_done_c)             state_d = ST_RECV;
        default:                             state_d = ST_RECV;
      endcase
    end
  end

  // Core datapath, flags and registered stream outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      finish_q   <= 1'b0;
      train_q    <= 1'b0;
      bias_q     <= '0;
      widx_q     <= '0;
      ridx_q     <= '0;
      oidx_q     <= '0;
      s_tready_q <= 1'b1;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else if (!core_en_c) begin
      finish_q   <= 1'b0;
      train_q    <= 1'b0;
      bias_q     <= '0;
      widx_q     <= '0;
      ridx_q     <= '0;
      oidx_q     <= '0;
      s_tready_q <= 1'b1;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      s_tready_q <= (state_d == ST_RECV);
      if (set_edge_c) begin
        train_q <= (reg_mode[MODE_LEN-1:0] == MODE_TRAIN);
      end
      if (next_edge_c) begin
        finish_q <= 1'b0;
      end
      case (state_q)
        ST_RECV: begin
          if (s_hs_c) begin
            if (S_AXIS_TLAST) begin
              widx_q <= '0;
            end else if (widx_q < WIDX_END) begin
              widx_q <= widx_q + (IDX_W + 1)'(1);
            end
          end
        end
        ST_WAIT: begin
          if (run_edge_c) begin
            finish_q <= 1'b0;
            ridx_q   <= '0;
          end
        end
        ST_RUN: begin
          if (run_done_c) begin
            finish_q   <= 1'b1;
            ridx_q     <= '0;
            oidx_q     <= '0;
            if (train_q) begin
              bias_q <= bias_q + CHAR_LEN'(1);
            end
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= (N == 1);
            // A one-entry batch has its only result being written this cycle
            m_tdata_q  <= (LAST_IDX == '0) ? run_char_c : out_buf[0];
          end else begin
            ridx_q <= ridx_q + IDX_W'(1);
          end
        end
        ST_OUT: begin
          if (out_done_c) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
            oidx_q     <= '0;
          end else if (m_hs_c) begin
            oidx_q    <= oidx_n_c;
            m_tdata_q <= out_buf[oidx_n_c];
            m_tlast_q <= next_last_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample and result buffers; contents are intentionally not reset
  always_ff @(posedge ACLK) begin
    if (wr_store_c) begin
      in_buf[widx_q[IDX_W-1:0]] <= S_AXIS_TDATA;
    end
    if (core_en_c && (state_q == ST_RUN)) begin
      out_buf[ridx_q] <= run_char_c;
    end
  end

`ifdef LED_STATUS_EN
  logic [3:0] led_q;

  // Status LEDs: {finish, RUN, WAIT, RECV}
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      led_q <= '0;
    end else begin
      led_q <= {finish_q, state_q == ST_RUN, state_q == ST_WAIT, state_q == ST_RECV};
    end
  end

  assign led_out = led_q;
`else
  assign led_out = 4'b0000;
`endif

endmodule

// File: tb/tb_train_top.sv
// tb_train_top: scoreboard bench for train_top. The stimulus process pushes
// expected stream beats and register reads into queues; one monitor process
// compares them against whatever the DUT presents.
module tb_train_top;

  localparam int unsigned CL = 8;
  localparam int unsigned NN = 4;
  localparam int unsigned BS = 2;
  localparam int unsigned ML = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

`ifdef LED_STATUS_EN
  localparam logic [3:0] LED_IDLE = 4'b0001;
`else
  localparam logic [3:0] LED_IDLE = 4'b0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    led_out;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [CL-1:0] s_tdata, m_tdata;
  logic          s_tlast, s_tvalid, s_tready;
  logic          m_tlast, m_tvalid, m_tready;

  train_top #(
    .CHAR_LEN(CL), .N(NN), .BATCH_SIZE(BS), .MODE_LEN(ML),
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .led_out(led_out),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready)
  );

  typedef struct packed {
    logic          last;
    logic [CL-1:0] data;
  } beat_t;

  beat_t         exp_m[$];
  logic [DW-1:0] rd_exp[$];
  bit            rd_chk[$];
  string         rd_name[$];

  int checks = 0;
  int failures = 0;
  int idle_req = 0;
  int idle_seen = 0;

  logic          prev_stall = 1'b0;
  logic [CL-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // Monitor: idle checks, stall stability, stream scoreboard, read scoreboard
  always @(negedge clk) begin
    beat_t         e;
    logic [DW-1:0] re;
    bit            rc;
    string         rn;
    if (rst_n) begin
      if (idle_req != idle_seen) begin
        idle_seen = idle_req;
        checks++;
        if (s_tready !== 1'b1) begin failures++; $display("FAIL idle_s_tready got=%b exp=1", s_tready); end
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL idle_m_tvalid got=%b exp=0", m_tvalid); end
        checks++;
        if ({m_tlast, m_tdata} !== 9'h000) begin failures++; $display("FAIL idle_m_out got=%h exp=000", {m_tlast, m_tdata}); end
        checks++;
        if (led_out !== LED_IDLE) begin failures++; $display("FAIL idle_led got=%h exp=%h", led_out, LED_IDLE); end
      end
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
          failures++;
          $display("FAIL m_hold got=v%b d%h l%b exp=v1 d%h l%b", m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_m.size() == 0) begin
          failures++;
          $display("FAIL m_unexpected got=d%h l%b exp=no beat", m_tdata, m_tlast);
        end else begin
          e = exp_m.pop_front();
          if (m_tdata !== e.data || m_tlast !== e.last) begin
            failures++;
            $display("FAIL m_beat got=d%h l%b exp=d%h l%b", m_tdata, m_tlast, e.data, e.last);
          end
        end
      end
      if (rvalid && rready) begin
        if (rd_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected got=%h exp=no read", rdata);
        end else begin
          re = rd_exp.pop_front();
          rc = rd_chk.pop_front();
          rn = rd_name.pop_front();
          if (rc) begin
            checks++;
            if (rdata !== re) begin failures++; $display("FAIL %s got=%h exp=%h", rn, rdata, re); end
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  function automatic void push1(input logic [CL-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_m.push_back(b);
  endfunction

  function automatic void push_range(input logic [CL-1:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      push1(base + CL'(i), (i % NN) == (NN - 1));
    end
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
    if (!awready) begin
      $display("FAIL axi_write_timeout got=no awready exp=awready addr=%h", a);
      $fatal(1, "write handshake timed out");
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic ctrl(input logic [DW-1:0] d);
    axi_write(4'h0, d, 4'hF);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input bit chk, input logic [DW-1:0] e,
                          input string nm, output logic [DW-1:0] d);
    int n = 0;
    rd_exp.push_back(e); rd_chk.push_back(chk); rd_name.push_back(nm);
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
    if (!arready) begin
      $display("FAIL axi_read_timeout got=no arready exp=arready addr=%h", a);
      $fatal(1, "read handshake timed out");
    end
    d = rdata;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic rd_check(input logic [AW-1:0] a, input logic [DW-1:0] e, input string nm);
    logic [DW-1:0] d;
    axi_read(a, 1'b1, e, nm, d);
  endtask

  task automatic wait_finish();
    logic [DW-1:0] d;
    int n = 0;
    do begin axi_read(4'h8, 1'b0, '0, "poll", d); n++; end while (!d[0] && n < 40);
    if (!d[0]) begin
      $display("FAIL finish_timeout got=%h exp=finish bit set", d);
      $fatal(1, "finish never rose");
    end
  endtask

  task automatic send_beat(input logic [CL-1:0] d, input logic l);
    int n = 0;
    @(posedge clk); #1;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 50) begin @(negedge clk); n++; end
    if (!s_tready) begin
      $display("FAIL s_tready_timeout got=0 exp=1 data=%h", d);
      $fatal(1, "input stream stalled");
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic stream(input int cnt, input logic [CL-1:0] base);
    for (int i = 0; i < cnt; i++) begin
      send_beat(base + CL'(i), i == cnt - 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_m.size() != 0 && n < 300) begin @(posedge clk); n++; end
    if (exp_m.size() != 0) begin
      $display("FAIL drain_timeout got=%0d pending exp=0 pending", exp_m.size());
      $fatal(1, "output stream incomplete");
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_req++;
    rd_check(4'h0, 32'h1, "reg0_reset");
    rd_check(4'h8, 32'h0, "reg2_reset");
    rd_check(4'h4, 32'h0, "reg1_reset");
    rd_check(4'hC, 32'h0, "reg3_zero");

    // TRAIN batch with bias 0; only byte 0 of the mode write is enabled
    stream(8, 8'h01);
    axi_write(4'h4, 32'hAABBCC01, 4'b0001);
    rd_check(4'h4, 32'h1, "reg1_wstrb");
    push_range(8'h01, 8);
    ctrl(32'h5);
    ctrl(32'h3);
    wait_finish();
    drain();
    rd_check(4'h8, 32'h1, "reg2_finish");

    // Second TRAIN batch sees bias 1
    ctrl(32'h9);
    rd_check(4'h8, 32'h0, "reg2_next_clears");
    stream(8, 8'h01);
    push_range(8'h02, 8);
    ctrl(32'h5);
    ctrl(32'h3);
    wait_finish();
    drain();

    // FORWARD with bias 2 returns sample 0 only
    ctrl(32'h9);
    stream(8, 8'h01);
    axi_write(4'h4, 32'h0, 4'hF);
    push_range(8'h03, 4);
    ctrl(32'h5);
    ctrl(32'h3);
    wait_finish();
    drain();

    // Backpressure: bias must still be 2, beats held while TREADY is low
    ctrl(32'h9);
    m_tready = 1'b0;
    stream(8, 8'h10);
    push_range(8'h12, 4);
    ctrl(32'h5);
    ctrl(32'h3);
    wait_finish();
    rd_check(4'h8, 32'h3, "reg2_busy_out");
    @(posedge clk); #1 m_tready = 1'b1;
    @(posedge clk); #1 m_tready = 1'b0;
    repeat (5) @(posedge clk);
    #1 m_tready = 1'b1;
    drain();

    // Core reset during RUN drops the batch and clears bias/mode/finish
    ctrl(32'h9);
    stream(8, 8'h20);
    axi_write(4'h4, 32'h1, 4'hF);
    ctrl(32'h5);
    ctrl(32'h3);
    ctrl(32'h2);
    repeat (20) @(posedge clk);
    #1 idle_req++;
    rd_check(4'h0, 32'h2, "reg0_preserved");
    rd_check(4'h8, 32'h0, "reg2_core_reset");
    rd_check(4'h4, 32'h1, "reg1_preserved");

    // Without a set edge the mode stays FORWARD after core reset, bias 0
    ctrl(32'h1);
    stream(8, 8'h30);
    push_range(8'h30, 4);
    ctrl(32'h3);
    wait_finish();
    drain();

    // Overlong stream: beats beyond the buffer are dropped
    ctrl(32'h9);
    stream(10, 8'h40);
    push_range(8'h40, 8);
    ctrl(32'h5);
    ctrl(32'h3);
    wait_finish();
    drain();

    // Early TLAST keeps older entries; bias is now 1
    ctrl(32'h9);
    stream(3, 8'h50);
    push1(8'h51, 1'b0); push1(8'h52, 1'b0); push1(8'h53, 1'b0); push1(8'h44, 1'b1);
    push1(8'h45, 1'b0); push1(8'h46, 1'b0); push1(8'h47, 1'b0); push1(8'h48, 1'b1);
    ctrl(32'h5);
    ctrl(32'h3);
    wait_finish();
    drain();
    rd_check(4'h8, 32'h1, "reg2_final");
    @(posedge clk); #1 idle_req++;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
